spi_sub: RTL and testbench

SPI subordinate (responder) for the team's MSB-first register-access SPI frame: CS low, one RW bit, ADDR_WIDTH address bits, DATA_WIDTH data bits. SCLK idles high and is oversampled by the local clk. The block decodes frames from an external SPI main and turns them into single-cycle register read/write strobes toward a local register file. It sits between the SPI pins and a register bank.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_sub.sv | 181 ++++++++++++++++++
 tb/tb_spi_sub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: subordinate FSM encoding and default frame geometry.
// Used by both the SPI main and subordinate so frame widths stay in lockstep.
package spi_pkg;

  localparam int SPI_ADDR_WIDTH  = 6;
  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RW      = 3'd1,
    S_ADDR    = 3'd2,
    S_FETCH   = 3'd3,
    S_DATA_TX = 3'd4,
    S_DATA_RX = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } spi_sub_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; pin to pulse is STAGES+1 clk.
// No backpressure. Edges are suppressed until the chain has refilled after reset.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic [STAGES:0]   prime_sr;
  logic              q_d;

  assign q = sync_sr[STAGES-1];

  // A level already present at reset release must not look like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr  <= {STAGES{RESET_VAL}};
      prime_sr <= '0;
      q_d      <= RESET_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_sr  <= {sync_sr[STAGES-2:0], d};
      prime_sr <= {prime_sr[STAGES-1:0], 1'b1};
      q_d      <= q;
      rise     <= prime_sr[STAGES] & q & ~q_d;
      fall     <= prime_sr[STAGES] & ~q & q_d;
    end
  end

endmodule

// File: rtl/spi_sub.sv
// SPI subordinate: decodes RW/ADDR/DATA frames into one-cycle reg_we/reg_re strobes.
// reg_re/reg_we one clk after the last address/data edge event; no backpressure (SPI main owns timing).
module spi_sub
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH  = SPI_ADDR_WIDTH,
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .q    (sclk_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs),
    .q    (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sr <= '0;
    else     mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sr[SYNC_STAGES-1];

  spi_sub_state_t state, state_n;
  logic [CNT_W-1:0]      bit_cnt, cnt_n;
  logic                  rw, rw_n;
  logic [ADDR_WIDTH-2:0] addr_sr;
  logic [DATA_WIDTH-2:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] rx_nxt;
  logic shift_addr, ld_addr, shift_rx, ld_wdata, shift_tx, ld_tx;
  logic re_n, we_n, err_n;

  assign addr_nxt = {addr_sr, mosi_s};
  assign rx_nxt   = {rx_sr, mosi_s};

  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    rw_n       = rw;
    shift_addr = 1'b0;
    ld_addr    = 1'b0;
    shift_rx   = 1'b0;
    ld_wdata   = 1'b0;
    shift_tx   = 1'b0;
    ld_tx      = 1'b0;
    re_n       = 1'b0;
    we_n       = 1'b0;
    err_n      = 1'b0;
    // cs release mid-frame wins over any coincident sclk edge.
    if (cs_rise && state != S_IDLE && state != S_DONE && state != S_ERROR) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) begin
          state_n = S_RW;
          cnt_n   = '0;
        end
        S_RW: if (sclk_rise) begin
          rw_n    = mosi_s;
          state_n = S_ADDR;
          cnt_n   = ADDR_LAST;
        end
        S_ADDR: if (sclk_rise) begin
          shift_addr = 1'b1;
          if (bit_cnt == '0) begin
            ld_addr = 1'b1;
            if (rw) begin
              state_n = S_DATA_RX;
              cnt_n   = DATA_LAST;
            end else begin
              state_n = S_FETCH;
              re_n    = 1'b1;
            end
          end else begin
            cnt_n = bit_cnt - 1'b1;
          end
        end
        // First cycle carries reg_re; reg_rdata is valid on the second.
        S_FETCH: if (!reg_re) begin
          ld_tx   = 1'b1;
          state_n = S_DATA_TX;
          cnt_n   = DATA_LAST;
        end
        // The falling edge before the first data sample must keep the MSB on miso.
        S_DATA_TX: begin
          if (sclk_fall && bit_cnt != DATA_LAST) shift_tx = 1'b1;
          if (sclk_rise) begin
            if (bit_cnt == '0) state_n = S_DONE;
            else               cnt_n   = bit_cnt - 1'b1;
          end
        end
        S_DATA_RX: if (sclk_rise) begin
          shift_rx = 1'b1;
          if (bit_cnt == '0) begin
            ld_wdata = 1'b1;
            we_n     = 1'b1;
            state_n  = S_DONE;
          end else begin
            cnt_n = bit_cnt - 1'b1;
          end
        end
        S_DONE:  if (cs_rise) state_n = S_IDLE;
        S_ERROR: state_n = S_IDLE;
        default: state_n = S_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      addr_sr   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      rw        <= rw_n;
      reg_re    <= re_n;
      reg_we    <= we_n;
      frame_err <= err_n;
      if (shift_addr) addr_sr   <= addr_nxt[ADDR_WIDTH-2:0];
      if (ld_addr)    reg_addr  <= addr_nxt;
      if (shift_rx)   rx_sr     <= rx_nxt[DATA_WIDTH-2:0];
      if (ld_wdata)   reg_wdata <= rx_nxt;
      if (ld_tx)         tx_sr <= reg_rdata;
      else if (shift_tx) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign miso    = (state == S_DATA_TX) & tx_sr[DATA_WIDTH-1];
  assign miso_oe = ~cs_sync;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_spi_sub.sv
// Bench for spi_sub: randomized SPI frames against a register-map reference model,
// strobes and read-back bytes checked through a scoreboard by an independent monitor.
module tb_spi_sub;
  import spi_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int K_WE = 0, K_RE = 1, K_ERR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b1, cs = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, reg_we, reg_re, busy, frame_err;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  spi_sub #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Register bank attached to the DUT; rdata is valid the cycle after reg_re.
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // Reference model: what the register map should hold after each complete write.
  logic [DW-1:0] ref_mem [64];

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] exp_miso[$];
  logic [DW-1:0] got_miso[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int            mon_k;
  exp_t          mon_e;
  logic [DW-1:0] mon_m;
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we || reg_re || frame_err) begin
        mon_k = reg_we ? K_WE : (reg_re ? K_RE : K_ERR);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_strobe: got kind %0d, expected none", mon_k);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", mon_k, mon_e.kind);
          if (mon_k != K_ERR) check("reg_addr", reg_addr, mon_e.addr);
          if (mon_k == K_WE)  check("reg_wdata", reg_wdata, mon_e.data);
        end
      end
      if (got_miso.size() > 0) begin
        mon_m = got_miso.pop_front();
        if (exp_miso.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got 0x%0h, expected none", mon_m);
        end else begin
          check("miso_byte", mon_m, exp_miso.pop_front());
        end
      end
    end
  end

  // SPI main, CPOL=1: mosi driven on sclk fall, miso sampled on sclk rise.
  task automatic frame(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int half, input int abort_after, input int extra,
                       input bit keep_low, input int gap);
    logic [AW+DW:0] bits;
    logic [DW-1:0]  cap;
    int             nbits;
    bits  = {rw, a, d};
    cap   = '0;
    nbits = (abort_after >= 0) ? 1 + AW + abort_after : 1 + AW + DW;
    cs = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = bits[AW+DW-i];
      repeat (half) @(negedge clk);
      if (i >= 1 + AW) cap = {cap[DW-2:0], miso};
      sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
    for (int i = 0; i < extra; i++) begin
      sclk = 1'b0;
      mosi = 1'($urandom);
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
    if (!rw && abort_after < 0) got_miso.push_back(cap);
    if (!keep_low) begin
      cs = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int half, input int gap);
    exp_q.push_back('{K_WE, a, d});
    ref_mem[a] = d;
    frame(1'b1, a, d, half, -1, 0, 1'b0, gap);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int half, input int gap);
    exp_q.push_back('{K_RE, a, '0});
    exp_miso.push_back(ref_mem[a]);
    frame(1'b0, a, '0, half, -1, 0, 1'b0, gap);
  endtask

  task automatic do_abort(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int half, input int after, input int gap);
    if (!rw) exp_q.push_back('{K_RE, a, '0});
    exp_q.push_back('{K_ERR, '0, '0});
    frame(rw, a, d, half, after, 0, 1'b0, gap);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[6'h15]     = 8'h96;
    ref_mem[6'h15] = 8'h96;

    repeat (3) @(negedge clk);
    check("rst_miso",      miso,      0);
    check("rst_miso_oe",   miso_oe,   0);
    check("rst_reg_addr",  reg_addr,  0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_strobes",   {reg_we, reg_re, frame_err}, 0);
    check("rst_busy",      busy,      0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    do_write(6'h2A, 8'hC5, 5, 4);
    check("miso_idle", miso, 0);
    do_read(6'h15, 5, 4);

    do_abort(1'b1, 6'h3F, 8'hAA, 5, 3, 6);
    check("abort_idle", busy, 0);
    do_write(6'h3F, 8'h01, 5, 4);

    exp_q.push_back('{K_WE, 6'h10, 8'h5A});
    ref_mem[6'h10] = 8'h5A;
    frame(1'b1, 6'h10, 8'h5A, 5, -1, 4, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("done_busy",  busy, 1);
    check("done_state", 32'(dut.state), 32'(S_DONE));
    cs = 1'b1;
    repeat (6) @(negedge clk);
    check("done_release", busy, 0);

    // Reset mid-address with cs held low across release.
    cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0; mosi = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      sclk = 1'b0; mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    check("post_rst_addr",  reg_addr,  0);
    check("post_rst_wdata", reg_wdata, 0);
    check("post_rst_busy",  busy,      0);
    check("post_rst_miso",  miso,      0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    do_read(6'h3F, 5, 3);

    do_read(6'(3), 4, 1);
    do_write(6'h07, 8'hE1, 4, 1);
    do_read(6'h07, 4, 1);

    for (int n = 0; n < 24; n++) begin
      bit            rw;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            half, gap;
      rw   = 1'($urandom);
      a    = AW'($urandom);
      d    = DW'($urandom);
      half = $urandom_range(4, 7);
      gap  = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0)
        do_abort(rw, a, d, half, $urandom_range(0, DW - 1), gap);
      else if (rw)
        do_write(a, d, half, gap);
      else
        do_read(a, half, gap);
    end

    for (int i = 0; i < 200 && (exp_q.size() != 0 || got_miso.size() != 0); i++)
      @(negedge clk);
    check("strobes_drained", exp_q.size(), 0);
    check("reads_drained",   exp_miso.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
